// File: rtl/sd_frame_ctrl_pkg.sv
// Shared constants for the SD frame front-end: FSM encoding, sample geometry, mode codes
// and the compare helpers used by the sort network.
package sd_frame_ctrl_pkg;

  localparam int unsigned SAMPLE_W  = 4;
  localparam int unsigned FRAME_LEN = 4;

  localparam logic MODE_DIV  = 1'b0;
  localparam logic MODE_DIFF = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_CALC    = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  function automatic logic [SAMPLE_W-1:0] max_s(input logic [SAMPLE_W-1:0] a,
                                                input logic [SAMPLE_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  function automatic logic [SAMPLE_W-1:0] min_s(input logic [SAMPLE_W-1:0] a,
                                                input logic [SAMPLE_W-1:0] b);
    return (a >= b) ? b : a;
  endfunction

endpackage

// File: rtl/sd_frame_ctrl_sd.sv
// Combinational SD core: sorts four samples descending, then either divides max by min
// or sums the two adjacent gaps.
module sd_frame_ctrl_sd
  import sd_frame_ctrl_pkg::*;
(
  input  logic [FRAME_LEN-1:0][SAMPLE_W-1:0] samples,
  input  logic                               mode,
  output logic [SAMPLE_W-1:0]                n
);

  logic [SAMPLE_W-1:0] hi01, lo01, hi23, lo23, mid_a, mid_b;
  logic [SAMPLE_W-1:0] s0, s1, s2, s3;

  // Five compare-exchanges: a full sorting network for four inputs.
  always_comb begin
    hi01  = max_s(samples[0], samples[1]);
    lo01  = min_s(samples[0], samples[1]);
    hi23  = max_s(samples[2], samples[3]);
    lo23  = min_s(samples[2], samples[3]);
    s0    = max_s(hi01, hi23);
    mid_a = min_s(hi01, hi23);
    mid_b = max_s(lo01, lo23);
    s3    = min_s(lo01, lo23);
    s1    = max_s(mid_a, mid_b);
    s2    = min_s(mid_a, mid_b);
  end

  always_comb begin
    n = '0;
    if (mode == MODE_DIV) begin
      n = (s3 == '0) ? '1 : s0 / s3;
    end else begin
      n = (s0 - s1) + (s2 - s3);
    end
  end

endmodule

// File: rtl/sd_frame_ctrl.sv
// Frames a serial 4-bit sample stream into 4-sample frames, runs one SD evaluation per
// frame and holds the registered result on a valid/ready output.
module sd_frame_ctrl
  import sd_frame_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_first,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_n,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);

  logic [1:0]                         state_q, state_d;
  logic [1:0]                         idx_q, idx_d;
  logic [FRAME_LEN-1:0][SAMPLE_W-1:0] samp_q, samp_d;
  logic                               mode_q, mode_d;
  logic [SAMPLE_W-1:0]                out_n_q, out_n_d;
  logic [CNT_W-1:0]                   frame_cnt_q, drop_cnt_q;
  logic                               frame_inc, drop_inc, accept;
  logic [SAMPLE_W-1:0]                sd_n;

  sd_frame_ctrl_sd u_sd (
    .samples (samp_q),
    .mode    (mode_q),
    .n       (sd_n)
  );

  // Decoded from registered state only, so in_valid never feeds back into in_ready.
  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign out_valid = (state_q == ST_HOLD);
  assign out_n     = out_n_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    samp_d    = samp_q;
    mode_d    = mode_q;
    out_n_d   = out_n_q;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_first) begin
            samp_d[0] = in_data;
            mode_d    = in_mode;
            idx_d     = 2'd1;
            state_d   = ST_COLLECT;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          if (in_first) begin
            drop_inc  = 1'b1;
            samp_d[0] = in_data;
            mode_d    = in_mode;
            idx_d     = 2'd1;
          end else begin
            samp_d[idx_q] = in_data;
            idx_d         = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        out_n_d = sd_n;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          frame_inc = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      samp_q      <= '0;
      mode_q      <= 1'b0;
      out_n_q     <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      samp_q  <= samp_d;
      mode_q  <= mode_d;
      out_n_q <= out_n_d;
      if (frame_inc && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if (drop_inc && (drop_cnt_q != '1))   drop_cnt_q  <= drop_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sd_frame_ctrl.sv
// Directed bench for sd_frame_ctrl: drives on the falling edge, checks between edges.
module tb_sd_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_first, in_mode;
  logic [3:0] in_data;
  logic       out_valid, out_ready;
  logic [3:0] out_n;
  logic [7:0] frame_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  int exp_drops = 0;

  sd_frame_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One beat presented for exactly one rising edge.
  task automatic beat(input logic [3:0] d, input logic f, input logic m);
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_mode  = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic m);
    beat(a, 1'b1, m);
    beat(b, 1'b0, m);
    beat(c, 1'b0, m);
    beat(d, 1'b0, m);
  endtask

  // Called right after the 4th beat's edge: checks latency, result and handshake.
  task automatic finish_frame(input string tag, input int exp_n);
    check({tag, "_calc_valid"}, 32'(out_valid), 0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_n"}, 32'(out_n), exp_n);
    check({tag, "_in_ready_hold"}, 32'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_frames++;
    check({tag, "_valid_drop"}, 32'(out_valid), 0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), exp_frames);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_mode = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_n", 32'(out_n), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    send4(4'd9, 4'd2, 4'd7, 4'd3, 1'b0);   finish_frame("div_9273", 4);
    send4(4'd9, 4'd2, 4'd7, 4'd3, 1'b1);   finish_frame("diff_9273", 3);
    send4(4'd15, 4'd0, 4'd0, 4'd0, 1'b1);  finish_frame("diff_15000", 15);
    send4(4'd5, 4'd0, 4'd8, 4'd1, 1'b0);   finish_frame("div_zero", 15);
    send4(4'd4, 4'd4, 4'd4, 4'd4, 1'b0);   finish_frame("div_4444", 1);

    // Backpressure: 14,9,3,2 -> 14/2 = 7, held while new beats are offered.
    send4(4'd14, 4'd2, 4'd9, 4'd3, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_first = 1'b1; in_data = 4'd1;
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_n", 32'(out_n), 7);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_frame_cnt", 32'(frame_cnt), exp_frames);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_frames++;
    check("bp_frame_cnt_hs", 32'(frame_cnt), exp_frames);
    check("bp_drop_cnt", 32'(drop_cnt), exp_drops);
    check("bp_valid_drop", 32'(out_valid), 0);

    // Restart on 3rd beat; new frame 10,6,2,1 mode1 -> 4+1 = 5.
    beat(4'd3, 1'b1, 1'b0);
    beat(4'd4, 1'b0, 1'b0);
    beat(4'd10, 1'b1, 1'b1);
    exp_drops++;
    check("restart_drop", 32'(drop_cnt), exp_drops);
    beat(4'd6, 1'b0, 1'b1);
    beat(4'd2, 1'b0, 1'b1);
    beat(4'd1, 1'b0, 1'b1);
    finish_frame("restart", 5);

    beat(4'd7, 1'b0, 1'b0);
    exp_drops++;
    check("orphan_drop", 32'(drop_cnt), exp_drops);
    check("orphan_valid", 32'(out_valid), 0);
    check("orphan_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    check("orphan_valid2", 32'(out_valid), 0);

    // Asynchronous reset mid-collect.
    beat(4'd9, 1'b1, 1'b0);
    beat(4'd2, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_c_in_ready", 32'(in_ready), 1);
    check("arst_c_frame_cnt", 32'(frame_cnt), 0);
    check("arst_c_drop_cnt", 32'(drop_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
    exp_drops = 0;

    // Asynchronous reset mid-hold.
    send4(4'd8, 4'd1, 4'd5, 4'd3, 1'b0);
    @(negedge clk);
    check("pre_arst_h_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_h_valid", 32'(out_valid), 0);
    check("arst_h_n", 32'(out_n), 0);
    check("arst_h_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_arst_valid", 32'(out_valid), 0);
      check("post_arst_frame_cnt", 32'(frame_cnt), 0);
    end
    out_ready = 1'b0;

    send4(4'd9, 4'd2, 4'd7, 4'd3, 1'b0);   finish_frame("post_arst", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
